bist_stim_ctrl: RTL and testbench
=================================

Name: bist_stim_ctrl

Overview:
- Drives the primary inputs of a benchmark sequential core (3 inputs: G0 clear, G1, G2) and compacts its 6 primary outputs into a signature.
- Pseudo-random stimulus comes from an LFSR; responses are folded into a MISR.
- An FSM runs the sequence: initialise the core, apply N patterns, drain the core latency, then report the signature.
- Sits beside the core as its self-test wrapper.

Parameters:
- PAT_W, 3: width of pat_out (core input count).
- RSP_W, 6: width of rsp_in (core output count).
- SIG_W, 16: LFSR and MISR width. Must satisfy SIG_W >= RSP_W and SIG_W >= PAT_W.
- N_PATTERNS, 1024: number of RUN cycles. Must be >= 1.
- INIT_CYCLES, 2: number of cycles the core clear (pat_out[0]) is held high before RUN. Must be >= 1.
- LAT, 1: core input-to-output latency in cycles. Must be >= 1.
- SEED, 16'h0001: LFSR load value. A value of 0 is replaced by 1.
- LFSR_POLY, 16'hB400: Galois LFSR feedback mask.
- MISR_POLY, 16'h1021: MISR feedback mask.

Ports:
- CK, input, 1: clock, rising edge.
- RST, input, 1: synchronous, active-high reset.
- start, input, 1: single-cycle request to begin a run. Sampled only in IDLE or DONE.
- pat_out, output, PAT_W: stimulus to the core (bit0 = G0, bit1 = G1, bit2 = G2).
- rsp_in, input, RSP_W: core outputs (G147, G148, G198, G199, G213, G214, in bit order 0..5).
- busy, output, 1: high in INIT, RUN and DRAIN.
- done, output, 1: high in DONE.
- signature, output, SIG_W: MISR contents. Valid while done is high.

Behaviour:
- Reset (RST=1 at an edge, in any state including mid-run): state becomes IDLE; lfsr=SEED (0 is forced to 1); misr=0; all counters 0; pat_out=0; busy=0; done=0; signature=0.
- All outputs are registered or decoded from state only. There is no combinational path from input to output.
- IDLE: pat_out=0.
  - start=1 → INIT, loading lfsr=SEED, misr=0, cnt=0.
- INIT: pat_out = {0,...,0,1} (G0=1 clears the core).
  - After INIT_CYCLES cycles → RUN, cnt=0.
- RUN: pat_out = lfsr[PAT_W-1:0] in every cycle.
  - Each cycle the LFSR advances: lfsr_next = lfsr[0] ? (lfsr>>1) ^ LFSR_POLY : lfsr>>1.
  - In the cycle where cnt = N_PATTERNS-1 → DRAIN.
  - The pattern applied in RUN cycle k is pattern k, counted from 0.
- DRAIN: pat_out=0.
  - Lasts exactly LAT cycles, then → DONE.
  - The LFSR holds its value.
- DONE: done=1; signature holds its value; pat_out=0.
  - start=1 → INIT, which clears misr and reloads lfsr, as from IDLE.
- Compaction:
  - A LAT-deep valid shift register is fed with (state==RUN).
  - When its output is 1, at that edge: misr_next = (misr<<1) ^ (misr[SIG_W-1] ? MISR_POLY : 0) ^ zero_extend(rsp_in).
  - Exactly N_PATTERNS compaction steps occur per run. Step k captures the response to pattern k.
  - Responses during INIT and DRAIN-only cycles are not compacted.
- start while busy=1 is ignored. start asserted in the same cycle as RST is ignored.
- Cycle count from the start edge to the first done=1 cycle is INIT_CYCLES + N_PATTERNS + LAT.
- The pattern counter is $clog2(N_PATTERNS+1) bits wide and the init counter $clog2(INIT_CYCLES+1) bits wide. No counter wraps within a run.

Decomposition:
- Shared package bist_pkg holds:
  - the state enum (IDLE, INIT, RUN, DRAIN, DONE);
  - default polynomial and seed constants;
  - a function lfsr_step(v, poly);
  - a function misr_step(v, poly, d).
- One sub-module, bist_misr: the parameterised compactor with ports CK, RST, clr, en, d, sig.
- LFSR and FSM stay in bist_stim_ctrl.

Test Plan:
- Reset then idle (no start): pat_out=0, busy=0, done=0 for 20 cycles. Reset mid-RUN: on the next cycle state is IDLE, pat_out=0, signature=0.
- Default params, start pulse: pat_out=3'b001 for 2 cycles; first RUN pattern 3'b001 (lfsr=0001); second 3'b000 (lfsr=B400). done rises exactly 2+1024+1 cycles after the start edge.
- N_PATTERNS=2, rsp_in held at 6'h01: signature=16'h0003. With rsp_in held at 0: signature=16'h0000.
- N_PATTERNS=1, LAT=3, rsp_in=6'h2A only in the compacted cycle and 0 otherwise: signature=16'h002A; DRAIN lasts 3 cycles.
- start pulsed during RUN: no effect, same done time and signature. start in DONE: done drops next cycle, misr clears, and the run repeats with an identical signature for an identical core.
- SEED=0: behaves identically to SEED=1 (first RUN pattern 3'b001).

Source files
------------

// File: rtl/bist_pkg.sv
// Shared types and step functions for the BIST stimulus/compaction wrapper.
// The step functions work on a wide vector; callers size-cast the result to their own width.
package bist_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [15:0] DEF_SEED      = 16'h0001;
  localparam logic [15:0] DEF_LFSR_POLY = 16'hB400;
  localparam logic [15:0] DEF_MISR_POLY = 16'h1021;

  localparam int unsigned STEP_W = 64;
  typedef logic [STEP_W-1:0] step_t;

  // Galois LFSR advance: shift right, fold the polynomial in when the LSB was set.
  function automatic step_t lfsr_step(step_t v, step_t poly);
    step_t r;
    if (v[0]) r = (v >> 1) ^ poly;
    else      r = v >> 1;
    return r;
  endfunction

  // MISR step of a w-bit register: shift left, feedback from bit w-1, xor in the data word.
  function automatic step_t misr_step(step_t v, step_t poly, step_t d, int unsigned w);
    step_t fb;
    if (((v >> (w - 32'd1)) & 64'd1) != 64'd0) fb = poly;
    else                                       fb = 64'd0;
    return (v << 1) ^ fb ^ d;
  endfunction

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register: clears on clr, compacts d on en.
module bist_misr
  import bist_pkg::*;
#(
  parameter int               SIG_W = 16,
  parameter int               D_W   = 6,
  parameter logic [SIG_W-1:0] POLY  = DEF_MISR_POLY
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             clr,
  input  logic             en,
  input  logic [D_W-1:0]   d,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_r;
  logic [SIG_W-1:0] step_s;

  // One compaction step of the current signature with the incoming response.
  always_comb begin
    step_s = SIG_W'(misr_step(step_t'(sig_r), step_t'(POLY), step_t'(d), SIG_W));
  end

  // Signature register; clear wins over compaction.
  always_ff @(posedge CK) begin
    if (RST)      sig_r <= '0;
    else if (clr) sig_r <= '0;
    else if (en)  sig_r <= step_s;
    else          sig_r <= sig_r;
  end

  assign sig = sig_r;

endmodule

// File: rtl/bist_stim_ctrl.sv
// Self-test wrapper: clears the core, applies LFSR patterns, drains the core latency
// and reports the MISR signature of the responses.
module bist_stim_ctrl
  import bist_pkg::*;
#(
  parameter int               PAT_W       = 3,
  parameter int               RSP_W       = 6,
  parameter int               SIG_W       = 16,
  parameter int               N_PATTERNS  = 1024,
  parameter int               INIT_CYCLES = 2,
  parameter int               LAT         = 1,
  parameter logic [SIG_W-1:0] SEED        = DEF_SEED,
  parameter logic [SIG_W-1:0] LFSR_POLY   = DEF_LFSR_POLY,
  parameter logic [SIG_W-1:0] MISR_POLY   = DEF_MISR_POLY
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             start,
  output logic [PAT_W-1:0] pat_out,
  input  logic [RSP_W-1:0] rsp_in,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature
);

  localparam int PC_W = $clog2(N_PATTERNS + 32'sd1);
  localparam int IC_W = $clog2(INIT_CYCLES + 32'sd1);
  localparam int DC_W = $clog2(LAT + 32'sd1);
  localparam logic [PC_W-1:0]  PAT_LAST   = PC_W'(N_PATTERNS - 32'sd1);
  localparam logic [IC_W-1:0]  INIT_LAST  = IC_W'(INIT_CYCLES - 32'sd1);
  localparam logic [DC_W-1:0]  DRAIN_LAST = DC_W'(LAT - 32'sd1);
  // An all-zero seed would lock the LFSR, so it is promoted to 1.
  localparam logic [SIG_W-1:0] SEED_EFF   = (SEED == '0) ? SIG_W'(1'b1) : SEED;

  state_t           state_r, state_nx_s;
  logic [SIG_W-1:0] lfsr_r, lfsr_nx_s;
  logic [PC_W-1:0]  pcnt_r, pcnt_nx_s;
  logic [IC_W-1:0]  icnt_r, icnt_nx_s;
  logic [DC_W-1:0]  dcnt_r, dcnt_nx_s;
  logic [LAT-1:0]   vld_r;
  logic [PAT_W-1:0] pat_r, pat_nx_s;
  logic             busy_r, done_r;
  logic             misr_clr_s;

  // Sequencer next state, counters and LFSR.
  always_comb begin
    state_nx_s = state_r;
    lfsr_nx_s  = lfsr_r;
    pcnt_nx_s  = pcnt_r;
    icnt_nx_s  = icnt_r;
    dcnt_nx_s  = dcnt_r;
    misr_clr_s = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_nx_s = INIT;
          lfsr_nx_s  = SEED_EFF;
          pcnt_nx_s  = '0;
          icnt_nx_s  = '0;
          dcnt_nx_s  = '0;
          misr_clr_s = 1'b1;
        end else begin
          state_nx_s = state_r;
        end
      end
      INIT: begin
        if (icnt_r == INIT_LAST) begin
          state_nx_s = RUN;
          pcnt_nx_s  = '0;
        end else begin
          icnt_nx_s = icnt_r + 1'b1;
        end
      end
      RUN: begin
        lfsr_nx_s = SIG_W'(lfsr_step(step_t'(lfsr_r), step_t'(LFSR_POLY)));
        if (pcnt_r == PAT_LAST) begin
          state_nx_s = DRAIN;
          dcnt_nx_s  = '0;
        end else begin
          pcnt_nx_s = pcnt_r + 1'b1;
        end
      end
      DRAIN: begin
        if (dcnt_r == DRAIN_LAST) begin
          state_nx_s = DONE;
        end else begin
          dcnt_nx_s = dcnt_r + 1'b1;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Pattern seen by the core in the upcoming cycle.
  always_comb begin
    pat_nx_s = '0;
    case (state_nx_s)
      INIT:    pat_nx_s = PAT_W'(1'b1);
      RUN:     pat_nx_s = lfsr_nx_s[PAT_W-1:0];
      default: pat_nx_s = '0;
    endcase
  end

  // State, counters and registered outputs; vld_r tracks which cycles carry a RUN response.
  always_ff @(posedge CK) begin
    if (RST) begin
      state_r <= IDLE;
      lfsr_r  <= SEED_EFF;
      pcnt_r  <= '0;
      icnt_r  <= '0;
      dcnt_r  <= '0;
      vld_r   <= '0;
      pat_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      lfsr_r  <= lfsr_nx_s;
      pcnt_r  <= pcnt_nx_s;
      icnt_r  <= icnt_nx_s;
      dcnt_r  <= dcnt_nx_s;
      vld_r   <= (vld_r << 1) | LAT'(state_r == RUN);
      pat_r   <= pat_nx_s;
      busy_r  <= (state_nx_s == INIT) || (state_nx_s == RUN) || (state_nx_s == DRAIN);
      done_r  <= (state_nx_s == DONE);
    end
  end

  bist_misr #(
    .SIG_W (SIG_W),
    .D_W   (RSP_W),
    .POLY  (MISR_POLY)
  ) u_misr (
    .CK  (CK),
    .RST (RST),
    .clr (misr_clr_s),
    .en  (vld_r[LAT-1]),
    .d   (rsp_in),
    .sig (signature)
  );

  assign pat_out = pat_r;
  assign busy    = busy_r;
  assign done    = done_r;

endmodule

// File: tb/tb_bist_stim_ctrl.sv
// Bench for bist_stim_ctrl: four parameterisations, each driving a table-based
// emulated core, checked cycle by cycle against a sequence-level model.
module tb_bist_stim_ctrl;

  logic CK = 1'b0;
  always #5 CK = ~CK;

  logic             rst_s   [4];
  logic             start_s [4];
  logic [2:0]       pat_s   [4];
  logic [5:0]       rsp_s   [4];
  logic             busy_s  [4];
  logic             done_s  [4];
  logic [15:0]      sig_s   [4];
  logic [7:0][5:0]  tbl_s   [4];
  logic [2:0]       hist_r  [4][4];

  int n_cmp = 0;
  int n_bad = 0;

  bist_stim_ctrl u_dut0 (
    .CK(CK), .RST(rst_s[0]), .start(start_s[0]), .pat_out(pat_s[0]), .rsp_in(rsp_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .signature(sig_s[0]));
  bist_stim_ctrl #(.N_PATTERNS(2)) u_dut1 (
    .CK(CK), .RST(rst_s[1]), .start(start_s[1]), .pat_out(pat_s[1]), .rsp_in(rsp_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .signature(sig_s[1]));
  bist_stim_ctrl #(.N_PATTERNS(1), .LAT(3)) u_dut2 (
    .CK(CK), .RST(rst_s[2]), .start(start_s[2]), .pat_out(pat_s[2]), .rsp_in(rsp_s[2]),
    .busy(busy_s[2]), .done(done_s[2]), .signature(sig_s[2]));
  bist_stim_ctrl #(.SEED(16'h0000), .N_PATTERNS(5), .INIT_CYCLES(1), .LAT(2)) u_dut3 (
    .CK(CK), .RST(rst_s[3]), .start(start_s[3]), .pat_out(pat_s[3]), .rsp_in(rsp_s[3]),
    .busy(busy_s[3]), .done(done_s[3]), .signature(sig_s[3]));

  function automatic int n_of(int i);
    case (i)
      0:       return 1024;
      1:       return 2;
      2:       return 1;
      default: return 5;
    endcase
  endfunction
  function automatic int init_of(int i);
    return (i == 3) ? 1 : 2;
  endfunction
  function automatic int lat_of(int i);
    case (i)
      2:       return 3;
      3:       return 2;
      default: return 1;
    endcase
  endfunction
  function automatic logic [15:0] seed_of(int i);
    return (i == 3) ? 16'h0001 : 16'h0001; // seed 0 on instance 3 must act as 1
  endfunction

  // Emulated core: response is a table lookup of the pattern applied LAT cycles earlier.
  always @(posedge CK) begin
    for (int i = 0; i < 4; i++) begin
      hist_r[i][0] <= pat_s[i];
      for (int j = 1; j < 4; j++) hist_r[i][j] <= hist_r[i][j-1];
    end
  end
  always_comb begin
    for (int i = 0; i < 4; i++) rsp_s[i] = tbl_s[i][hist_r[i][lat_of(i)-1]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_adv(logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  // Signature of the whole run: pattern k is the k-th LFSR value, response k is table[pattern k].
  function automatic logic [15:0] model_sig(int i);
    logic [15:0] l, m;
    l = seed_of(i);
    m = 16'h0000;
    for (int k = 0; k < n_of(i); k++) begin
      m = {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000) ^ {10'h000, tbl_s[i][l[2:0]]};
      l = lfsr_adv(l);
    end
    return m;
  endfunction

  task automatic run_inst(input int i, input bit mid);
    int          ni, ii, tot;
    logic [15:0] l, sexp;
    logic [4:0]  want;
    ni   = n_of(i);
    ii   = init_of(i);
    tot  = ii + ni + lat_of(i);
    l    = seed_of(i);
    sexp = model_sig(i);
    repeat ($urandom_range(0, 3)) @(negedge CK);
    start_s[i] = 1'b1;
    @(negedge CK);
    start_s[i] = 1'b0;
    for (int c = 0; c <= tot; c++) begin
      if (c < ii) want = 5'b10001;
      else if (c < ii + ni) begin
        want = {2'b10, l[2:0]};
        l = lfsr_adv(l);
      end
      else if (c < tot) want = 5'b10000;
      else want = 5'b01000;
      chk($sformatf("cyc_i%0d_c%0d", i, c), {27'h0, busy_s[i], done_s[i], pat_s[i]}, {27'h0, want});
      if (c == 0) chk($sformatf("clr_i%0d", i), {16'h0, sig_s[i]}, 32'h0);
      if (c == tot) chk($sformatf("sig_i%0d", i), {16'h0, sig_s[i]}, {16'h0, sexp});
      start_s[i] = (mid && c == ii + 1) ? 1'b1 : 1'b0;
      if (c < tot) @(negedge CK);
    end
    start_s[i] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      rst_s[i]   = 1'b1;
      start_s[i] = 1'b0;
      tbl_s[i]   = '0;
    end
    repeat (2) @(negedge CK);
    for (int i = 0; i < 4; i++) rst_s[i] = 1'b0;
    for (int i = 0; i < 4; i++) chk($sformatf("rst_sig_i%0d", i), {16'h0, sig_s[i]}, 32'h0);
    for (int c = 0; c < 20; c++) begin
      @(negedge CK);
      for (int i = 0; i < 4; i++)
        chk($sformatf("idle_i%0d", i), {29'h0, busy_s[i], done_s[i], pat_s[i][0]}, 32'h0);
    end

    // Default parameters: random core, then a repeat from DONE with a stray start mid-run.
    tbl_s[0] = 48'({$urandom(), $urandom()});
    run_inst(0, 1'b0);
    run_inst(0, 1'b1);

    // Reset in the middle of RUN, then reset together with start.
    start_s[0] = 1'b1;
    @(negedge CK);
    start_s[0] = 1'b0;
    repeat (10) @(negedge CK);
    rst_s[0] = 1'b1;
    @(negedge CK);
    rst_s[0] = 1'b0;
    chk("midrst_ctl", {27'h0, busy_s[0], done_s[0], pat_s[0]}, 32'h0);
    chk("midrst_sig", {16'h0, sig_s[0]}, 32'h0);
    rst_s[0]   = 1'b1;
    start_s[0] = 1'b1;
    @(negedge CK);
    rst_s[0]   = 1'b0;
    start_s[0] = 1'b0;
    chk("rst_start", {27'h0, busy_s[0], done_s[0], pat_s[0]}, 32'h0);
    tbl_s[0] = 48'({$urandom(), $urandom()});
    run_inst(0, 1'b0);

    // Two patterns with constant responses.
    tbl_s[1] = {8{6'h01}};
    run_inst(1, 1'b0);
    chk("n2_rsp01", {16'h0, sig_s[1]}, 32'h0003);
    tbl_s[1] = '0;
    run_inst(1, 1'b0);
    chk("n2_rsp00", {16'h0, sig_s[1]}, 32'h0000);
    tbl_s[1] = 48'({$urandom(), $urandom()});
    run_inst(1, 1'b0);

    // One pattern, three-cycle latency; only pattern 3'b001 answers 6'h2A.
    tbl_s[2]    = '0;
    tbl_s[2][1] = 6'h2A;
    run_inst(2, 1'b0);
    chk("lat3_sig", {16'h0, sig_s[2]}, 32'h002A);
    tbl_s[2] = 48'({$urandom(), $urandom()});
    run_inst(2, 1'b0);

    // Zero seed behaves like seed 1.
    for (int r = 0; r < 3; r++) begin
      tbl_s[3] = 48'({$urandom(), $urandom()});
      run_inst(3, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
